// File: rtl/sc_quaddec_pkg.sv
// Shared encodings and helpers for the quadrature decoder slice.
// Optional glitch filter is selected with SC_QUADDEC_GLITCH_FILTER_EN.
package sc_quaddec_pkg;

  typedef enum logic [1:0] {
    QD_S00 = 2'b00,
    QD_S01 = 2'b01,
    QD_S10 = 2'b10,
    QD_S11 = 2'b11
  } qd_state_e;

  localparam int   QD_FILT_W  = 4;
  localparam logic QD_DIR_FWD = 1'b1;
  localparam logic QD_DIR_REV = 1'b0;

  // State {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  function automatic qd_state_e qd_next_fwd(input qd_state_e s);
    case (s)
      QD_S00:  return QD_S10;
      QD_S10:  return QD_S11;
      QD_S11:  return QD_S01;
      QD_S01:  return QD_S00;
      default: return QD_S00;
    endcase
  endfunction

  function automatic qd_state_e qd_next_rev(input qd_state_e s);
    case (s)
      QD_S00:  return QD_S01;
      QD_S01:  return QD_S11;
      QD_S11:  return QD_S10;
      QD_S10:  return QD_S00;
      default: return QD_S00;
    endcase
  endfunction

endpackage

// File: rtl/sc_quaddec_filter.sv
// Per-channel 2-FF synchroniser plus stability filter.
// The filter exists only when SC_QUADDEC_GLITCH_FILTER_EN is defined.
module sc_quaddec_filter
  import sc_quaddec_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  logic sync1_r;
  logic sync2_r;

  if ((FILTER_LEN < 1) || (FILTER_LEN > 15)) begin : g_bad_len
    $error("sc_quaddec_filter: FILTER_LEN out of range 1..15");
  end

  // Synchroniser runs free so the pin level is already known when reset lifts.
  always_ff @(posedge clk) begin
    sync1_r <= raw;
    sync2_r <= sync1_r;
  end

`ifdef SC_QUADDEC_GLITCH_FILTER_EN
  localparam logic [QD_FILT_W-1:0] CNT_LAST = QD_FILT_W'(FILTER_LEN - 1);

  logic [QD_FILT_W-1:0] cnt_r;
  logic                 filt_r;

  // Accept a new level only after it has been stable for FILTER_LEN samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= {QD_FILT_W{1'b0}};
      filt_r <= sync2_r;
    end else if (sync2_r != filt_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r  <= {QD_FILT_W{1'b0}};
        filt_r <= sync2_r;
      end else begin
        cnt_r  <= cnt_r + {{(QD_FILT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= {QD_FILT_W{1'b0}};
    end
  end

  assign filt = filt_r;
`else
  assign filt = sync2_r;
`endif

endmodule

// File: rtl/sc_quadrature_decoder.sv
// x4 quadrature decoder: conditioned A/B phases -> signed position, step, dir, error.
// Glitch filtering is enabled with SC_QUADDEC_GLITCH_FILTER_EN.
module sc_quadrature_decoder
  import sc_quaddec_pkg::*;
#(
  parameter int N_POSITION = 16,
  parameter int FILTER_LEN = 4
) (
  input  logic                         SC_QUADDEC_CLOCK_50,
  input  logic                         SC_QUADDEC_RESET_InLow,
  input  logic                         SC_QUADDEC_A_In,
  input  logic                         SC_QUADDEC_B_In,
  input  logic                         SC_QUADDEC_CLEAR_InLow,
  output logic signed [N_POSITION-1:0] SC_QUADDEC_POSITION_OutBus,
  output logic                         SC_QUADDEC_STEP_Out,
  output logic                         SC_QUADDEC_DIR_Out,
  output logic                         SC_QUADDEC_ERROR_Out
);

  localparam logic [N_POSITION-1:0] POS_ONE = {{(N_POSITION-1){1'b0}}, 1'b1};

  logic                  a_filt_s;
  logic                  b_filt_s;
  qd_state_e             state_s;
  qd_state_e             prev_r;
  logic [N_POSITION-1:0] position_r;
  logic                  step_r;
  logic                  dir_r;
  logic                  error_r;

  logic [N_POSITION-1:0] pos_step_s;
  logic                  err_step_s;
  logic [N_POSITION-1:0] position_nxt_s;
  logic                  step_nxt_s;
  logic                  dir_nxt_s;
  logic                  error_nxt_s;

  sc_quaddec_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk   (SC_QUADDEC_CLOCK_50),
    .rst_n (SC_QUADDEC_RESET_InLow),
    .raw   (SC_QUADDEC_A_In),
    .filt  (a_filt_s)
  );

  sc_quaddec_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk   (SC_QUADDEC_CLOCK_50),
    .rst_n (SC_QUADDEC_RESET_InLow),
    .raw   (SC_QUADDEC_B_In),
    .filt  (b_filt_s)
  );

  assign state_s = qd_state_e'({a_filt_s, b_filt_s});

  // Classify the state change; clear wins over the position/error update only.
  always_comb begin
    pos_step_s = position_r;
    err_step_s = error_r;
    step_nxt_s = 1'b0;
    dir_nxt_s  = dir_r;
    if (state_s == prev_r) begin
      step_nxt_s = 1'b0;
    end else if (state_s == qd_next_fwd(prev_r)) begin
      pos_step_s = position_r + POS_ONE;
      step_nxt_s = 1'b1;
      dir_nxt_s  = QD_DIR_FWD;
    end else if (state_s == qd_next_rev(prev_r)) begin
      pos_step_s = position_r - POS_ONE;
      step_nxt_s = 1'b1;
      dir_nxt_s  = QD_DIR_REV;
    end else begin
      err_step_s = 1'b1;
    end
    if (!SC_QUADDEC_CLEAR_InLow) begin
      position_nxt_s = {N_POSITION{1'b0}};
      error_nxt_s    = 1'b0;
    end else begin
      position_nxt_s = pos_step_s;
      error_nxt_s    = err_step_s;
    end
  end

  // Output and history registers.
  always_ff @(posedge SC_QUADDEC_CLOCK_50) begin
    if (!SC_QUADDEC_RESET_InLow) begin
      prev_r     <= state_s;
      position_r <= {N_POSITION{1'b0}};
      step_r     <= 1'b0;
      dir_r      <= QD_DIR_REV;
      error_r    <= 1'b0;
    end else begin
      prev_r     <= state_s;
      position_r <= position_nxt_s;
      step_r     <= step_nxt_s;
      dir_r      <= dir_nxt_s;
      error_r    <= error_nxt_s;
    end
  end

  assign SC_QUADDEC_POSITION_OutBus = position_r;
  assign SC_QUADDEC_STEP_Out        = step_r;
  assign SC_QUADDEC_DIR_Out         = dir_r;
  assign SC_QUADDEC_ERROR_Out       = error_r;

endmodule

// File: tb/tb_sc_quadrature_decoder.sv
// Directed self-checking bench for sc_quadrature_decoder (N_POSITION=8, FILTER_LEN=4).
// Expectations adapt to whether SC_QUADDEC_GLITCH_FILTER_EN is defined.
module tb_sc_quadrature_decoder;

  localparam int NP = 8;
  localparam int FL = 4;
`ifdef SC_QUADDEC_GLITCH_FILTER_EN
  localparam int FLE = FL;
  localparam int LAT = FL + 2;
`else
  localparam int FLE = 1;
  localparam int LAT = 2;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          a     = 1'b1;
  logic          b     = 1'b1;
  logic          clr   = 1'b1;
  logic [NP-1:0] pos;
  logic          step;
  logic          dir;
  logic          err;

  int n_tests  = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int snap     = 0;
  int lat_seen = 0;

  // Forward successor of {A,B}: 00->10->11->01->00
  logic [1:0] fwd_tab [4];
  logic [1:0] cur;

  sc_quadrature_decoder #(.N_POSITION(NP), .FILTER_LEN(FL)) dut (
    .SC_QUADDEC_CLOCK_50        (clk),
    .SC_QUADDEC_RESET_InLow     (rst_n),
    .SC_QUADDEC_A_In            (a),
    .SC_QUADDEC_B_In            (b),
    .SC_QUADDEC_CLEAR_InLow     (clr),
    .SC_QUADDEC_POSITION_OutBus (pos),
    .SC_QUADDEC_STEP_Out        (step),
    .SC_QUADDEC_DIR_Out         (dir),
    .SC_QUADDEC_ERROR_Out       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (step === 1'b1) step_cnt <= step_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input logic [1:0] ab, input int hold);
    a = ab[1];
    b = ab[0];
    cyc(hold);
  endtask

  initial begin
    fwd_tab[0] = 2'b10;
    fwd_tab[1] = 2'b00;
    fwd_tab[2] = 2'b11;
    fwd_tab[3] = 2'b01;

    // Reset held with both pins high
    cyc(5);
    check("rst_pos",  32'(pos),  32'h0);
    check("rst_step", 32'(step), 32'h0);
    check("rst_dir",  32'(dir),  32'h0);
    check("rst_err",  32'(err),  32'h0);
    rst_n = 1'b1;
    snap = step_cnt;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      check("idle_step", 32'(step), 32'h0);
    end
    cyc(1);
    check("idle_cnt", 32'(step_cnt - snap), 32'h0);
    check("idle_pos", 32'(pos), 32'h0);
    check("idle_err", 32'(err), 32'h0);

    // Walk 11 -> 01 -> 00 forward, then clear
    move(2'b01, 10);
    move(2'b00, 10);
    check("walk_pos", 32'(pos), 32'h02);
    clr = 1'b0;
    cyc(1);
    clr = 1'b1;
    check("clr_pos", 32'(pos), 32'h00);

    // Forward run: 32 transitions, first one timed
    snap = step_cnt;
    cur = 2'b00;
    cur = fwd_tab[cur];
    a = cur[1];
    b = cur[0];
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if ((step === 1'b1) && (lat_seen == 0)) lat_seen = i;
    end
    check("latency", 32'(lat_seen), 32'(LAT + 1));
    for (int t = 1; t < 32; t++) begin
      cur = fwd_tab[cur];
      move(cur, 10);
    end
    cyc(2);
    check("fwd_steps", 32'(step_cnt - snap), 32'd32);
    check("fwd_pos",   32'(pos), 32'h20);
    check("fwd_dir",   32'(dir), 32'h1);

    // Reverse wrap from zero
    clr = 1'b0;
    cyc(1);
    clr = 1'b1;
    move(2'b01, 10);
    check("rev_pos", 32'(pos), 32'hFF);
    check("rev_dir", 32'(dir), 32'h0);
    move(2'b00, 10);
    check("wrap_pos", 32'(pos), 32'h00);
    check("wrap_dir", 32'(dir), 32'h1);

    // Glitch pulses on A: pulses shorter than the filter length vanish
    for (int g = 1; g <= 4; g++) begin
      if (g != 2) begin
        snap = step_cnt;
        a = 1'b1;
        cyc(g);
        a = 1'b0;
        cyc(20);
        check($sformatf("glitch%0d_steps", g), 32'(step_cnt - snap), (g >= FLE) ? 32'd2 : 32'd0);
        check($sformatf("glitch%0d_pos", g), 32'(pos), 32'h00);
        check($sformatf("glitch%0d_err", g), 32'(err), 32'h0);
      end
    end

    // Double transition 00 -> 11
    snap = step_cnt;
    move(2'b11, 20);
    check("dbl_err",   32'(err), 32'h1);
    check("dbl_pos",   32'(pos), 32'h00);
    check("dbl_steps", 32'(step_cnt - snap), 32'h0);
    cyc(5);
    check("dbl_sticky", 32'(err), 32'h1);
    clr = 1'b0;
    cyc(1);
    clr = 1'b1;
    check("dbl_clr_err", 32'(err), 32'h0);
    check("dbl_clr_pos", 32'(pos), 32'h00);

    // Clear colliding with a forward step
    move(2'b01, 10);
    check("pre_coll_pos", 32'(pos), 32'h01);
    a = 1'b0;
    b = 1'b0;
    cyc(LAT);
    clr = 1'b0;
    cyc(1);
    check("coll_step", 32'(step), 32'h1);
    check("coll_dir",  32'(dir),  32'h1);
    check("coll_pos",  32'(pos),  32'h00);
    clr = 1'b1;
    cyc(10);
    check("coll_pos_after", 32'(pos), 32'h00);

    // Reset in the middle of a filter count
    move(2'b10, 10);
    check("pre_rst_pos", 32'(pos), 32'h01);
    a = 1'b1;
    b = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    cyc(3);
    check("mid_rst_pos",  32'(pos),  32'h00);
    check("mid_rst_step", 32'(step), 32'h0);
    check("mid_rst_dir",  32'(dir),  32'h0);
    check("mid_rst_err",  32'(err),  32'h0);
    rst_n = 1'b1;
    snap = step_cnt;
    cyc(20);
    check("post_rst_steps", 32'(step_cnt - snap), 32'h0);
    check("post_rst_pos",   32'(pos), 32'h00);
    check("post_rst_err",   32'(err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
